// File: rtl/m_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for one shared memory port.
// Optional IF anti-starvation guard is enabled by defining M_MEM_ARBITER_STARVE_GUARD_EN.
module m_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_if_req,
    input  logic [ADDR_W-1:0] w_if_addr,
    output logic              w_if_gnt,
    output logic              w_if_rvalid,
    output logic [DATA_W-1:0] w_if_rdata,
    input  logic              w_d_req,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [DATA_W-1:0] w_d_wdata,
    output logic              w_d_gnt,
    output logic              w_d_rvalid,
    output logic [DATA_W-1:0] w_d_rdata,
    output logic              w_m_en,
    output logic              w_m_we,
    output logic [ADDR_W-1:0] w_m_addr,
    output logic [DATA_W-1:0] w_m_wdata,
    input  logic [DATA_W-1:0] w_m_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1) begin : g_bad_cfg
        $error("m_mem_arbiter: MEM_LAT must be 1..7 and STARVE_MAX >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;    // 1 = load/store port owns the read
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic arb_en;
    logic force_if;
    logic d_win;
    logic if_win;

    // Combinational outputs are gated by reset so nothing leaks while it is held.
    assign arb_en = (state_q == S_IDLE) && w_rst_n;
    assign d_win  = arb_en && w_d_req && !(force_if && w_if_req);
    assign if_win = arb_en && w_if_req && !d_win;

`ifdef M_MEM_ARBITER_STARVE_GUARD_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_if = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (if_win) begin
            starve_d = '0;
        end else if (d_win && w_if_req && !force_if) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        w_if_gnt  = if_win;
        w_d_gnt   = d_win;
        w_m_en    = if_win || d_win;
        w_m_we    = d_win && w_d_we;
        w_m_addr  = '0;
        w_m_wdata = '0;
        if (d_win) begin
            w_m_addr  = w_d_addr;
            w_m_wdata = w_d_wdata;
        end else if (if_win) begin
            w_m_addr  = w_if_addr;
        end
    end

    assign w_if_rvalid = (state_q == S_RESP) && !owner_q;
    assign w_d_rvalid  = (state_q == S_RESP) && owner_q;
    assign w_if_rdata  = rdata_q;
    assign w_d_rdata   = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                // Stores complete in the grant cycle; only reads need the latency wait.
                if (if_win || (d_win && !w_d_we)) begin
                    owner_d = d_win;
                    cnt_d   = 3'(MEM_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    rdata_d = w_m_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter: DUT a uses MEM_LAT=1, DUT b uses MEM_LAT=3.
module tb_m_mem_arbiter;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;

    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] b_s1, b_s2;

    m_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_if_req(a_if_req), .w_if_addr(a_if_addr), .w_if_gnt(a_if_gnt),
        .w_if_rvalid(a_if_rvalid), .w_if_rdata(a_if_rdata),
        .w_d_req(a_d_req), .w_d_we(a_d_we), .w_d_addr(a_d_addr), .w_d_wdata(a_d_wdata),
        .w_d_gnt(a_d_gnt), .w_d_rvalid(a_d_rvalid), .w_d_rdata(a_d_rdata),
        .w_m_en(a_m_en), .w_m_we(a_m_we), .w_m_addr(a_m_addr), .w_m_wdata(a_m_wdata),
        .w_m_rdata(a_m_rdata)
    );

    m_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_if_req(b_if_req), .w_if_addr(b_if_addr), .w_if_gnt(b_if_gnt),
        .w_if_rvalid(b_if_rvalid), .w_if_rdata(b_if_rdata),
        .w_d_req(b_d_req), .w_d_we(b_d_we), .w_d_addr(b_d_addr), .w_d_wdata(b_d_wdata),
        .w_d_gnt(b_d_gnt), .w_d_rvalid(b_d_rvalid), .w_d_rdata(b_d_rdata),
        .w_m_en(b_m_en), .w_m_we(b_m_we), .w_m_addr(b_m_addr), .w_m_wdata(b_m_wdata),
        .w_m_rdata(b_m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory a: one-cycle synchronous read; memory b: three-stage read pipeline.
    always @(posedge clk) begin
        if (a_m_en && a_m_we) mem_a[6'(a_m_addr >> 2)] <= a_m_wdata;
        if (a_m_en && !a_m_we) a_m_rdata <= mem_a[6'(a_m_addr >> 2)];
        if (b_m_en && b_m_we) mem_b[6'(b_m_addr >> 2)] <= b_m_wdata;
        if (b_m_en && !b_m_we) b_s1 <= mem_b[6'(b_m_addr >> 2)];
        b_s2      <= b_s1;
        b_m_rdata <= b_s2;
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_all();
        a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;
    endtask

    task automatic test_reset();
        nxt();
        rst_n = 1'b0;
        a_if_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h8; a_d_wdata = 32'h5;
        b_if_req = 1'b1; b_if_addr = 32'h4;
        #1;
        checks++; if (a_if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt: got %0h exp 0", a_if_gnt); end
        checks++; if (a_d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt: got %0h exp 0", a_d_gnt); end
        checks++; if (a_m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en: got %0h exp 0", a_m_en); end
        checks++; if (a_m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we: got %0h exp 0", a_m_we); end
        checks++; if (a_m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr: got %0h exp 0", a_m_addr); end
        checks++; if (a_m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata: got %0h exp 0", a_m_wdata); end
        checks++; if ({a_if_rvalid, a_d_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %0b exp 00", {a_if_rvalid, a_d_rvalid}); end
        checks++; if (a_if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %0h exp 0", a_if_rdata); end
        checks++; if (b_if_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt: got %0h exp 0", b_if_gnt); end
        nxt();
        idle_all();
        rst_n = 1'b1;
        #1;
        checks++; if (a_m_en !== 1'b0) begin errors++; $display("FAIL idle_m_en: got %0h exp 0", a_m_en); end
        nxt();
    endtask

    task automatic test_fetch_alone();
        nxt(); a_if_req = 1'b1; a_if_addr = 32'h0; #1;
        checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %0h exp 1", a_if_gnt); end
        checks++; if (a_m_en !== 1'b1) begin errors++; $display("FAIL fetch_m_en: got %0h exp 1", a_m_en); end
        checks++; if (a_m_we !== 1'b0) begin errors++; $display("FAIL fetch_m_we: got %0h exp 0", a_m_we); end
        checks++; if (a_m_addr !== 32'h0) begin errors++; $display("FAIL fetch_m_addr: got %0h exp 0", a_m_addr); end
        nxt(); a_if_req = 1'b0; #1;
        checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid: got %0h exp 0", a_if_rvalid); end
        nxt(); #1;
        checks++; if (a_if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %0h exp 1", a_if_rvalid); end
        checks++; if (a_if_rdata !== 32'h00700093) begin errors++; $display("FAIL fetch_rdata: got %0h exp 00700093", a_if_rdata); end
        checks++; if (a_d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid: got %0h exp 0", a_d_rvalid); end
        nxt(); #1;
        checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_pulse: got %0h exp 0", a_if_rvalid); end
        nxt();
    endtask

    task automatic test_reset_mid_read();
        nxt(); a_if_req = 1'b1; a_if_addr = 32'h0; #1;
        checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %0h exp 1", a_if_gnt); end
        nxt(); a_if_req = 1'b0; rst_n = 1'b0; #1;
        checks++; if (a_if_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata_clr: got %0h exp 0", a_if_rdata); end
        checks++; if ({a_if_rvalid, a_if_gnt, a_m_en} !== 3'b000) begin errors++; $display("FAIL midrst_outs: got %0b exp 000", {a_if_rvalid, a_if_gnt, a_m_en}); end
        nxt(); nxt(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({a_if_rvalid, a_d_rvalid} !== 2'b00) begin errors++; $display("FAIL midrst_no_rvalid: cycle %0d got %0b exp 00", i, {a_if_rvalid, a_d_rvalid}); end
            nxt();
        end
        a_if_req = 1'b1; a_if_addr = 32'h4; #1;
        checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL midrst_regrant: got %0h exp 1", a_if_gnt); end
        nxt(); a_if_req = 1'b0;
        nxt(); #1;
        checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'h11111111) begin errors++; $display("FAIL midrst_resp: got %0b/%0h exp 1/11111111", a_if_rvalid, a_if_rdata); end
        nxt();
    endtask

    task automatic test_simultaneous();
        nxt(); a_if_req = 1'b1; a_if_addr = 32'h4; a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h8; #1;
        checks++; if ({a_d_gnt, a_if_gnt} !== 2'b10) begin errors++; $display("FAIL sim_t_gnts: got %0b exp 10", {a_d_gnt, a_if_gnt}); end
        checks++; if (a_m_addr !== 32'h8) begin errors++; $display("FAIL sim_t_addr: got %0h exp 8", a_m_addr); end
        nxt(); a_d_req = 1'b0; #1;
        checks++; if (a_if_gnt !== 1'b0) begin errors++; $display("FAIL sim_t1_if_gnt: got %0h exp 0", a_if_gnt); end
        nxt(); #1;
        checks++; if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'h22222222) begin errors++; $display("FAIL sim_t2_d_resp: got %0b/%0h exp 1/22222222", a_d_rvalid, a_d_rdata); end
        checks++; if ({a_if_gnt, a_if_rvalid} !== 2'b00) begin errors++; $display("FAIL sim_t2_if: got %0b exp 00", {a_if_gnt, a_if_rvalid}); end
        nxt(); #1;
        checks++; if (a_if_gnt !== 1'b1 || a_m_addr !== 32'h4) begin errors++; $display("FAIL sim_t3_if_gnt: got %0b/%0h exp 1/4", a_if_gnt, a_m_addr); end
        nxt(); a_if_req = 1'b0;
        nxt(); #1;
        checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'h11111111) begin errors++; $display("FAIL sim_t5_if_resp: got %0b/%0h exp 1/11111111", a_if_rvalid, a_if_rdata); end
        checks++; if (a_d_rvalid !== 1'b0 || a_d_rdata !== 32'h11111111) begin errors++; $display("FAIL sim_t5_d_side: got %0b/%0h exp 0/11111111", a_d_rvalid, a_d_rdata); end
        nxt();
    endtask

    task automatic test_store_load();
        nxt(); a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h8; a_d_wdata = 32'd7; #1;
        checks++; if (a_d_gnt !== 1'b1 || a_m_we !== 1'b1) begin errors++; $display("FAIL st_gnt_we: got %0b/%0b exp 1/1", a_d_gnt, a_m_we); end
        checks++; if (a_m_addr !== 32'h8 || a_m_wdata !== 32'd7) begin errors++; $display("FAIL st_addr_data: got %0h/%0h exp 8/7", a_m_addr, a_m_wdata); end
        nxt(); a_d_we = 1'b0; a_d_wdata = 32'h0; #1;
        checks++; if (a_d_gnt !== 1'b1 || a_m_we !== 1'b0) begin errors++; $display("FAIL ld_gnt: got %0b/%0b exp 1/0", a_d_gnt, a_m_we); end
        checks++; if (a_d_rvalid !== 1'b0) begin errors++; $display("FAIL st_no_rvalid: got %0h exp 0", a_d_rvalid); end
        nxt(); a_d_req = 1'b0; #1;
        checks++; if (a_d_rvalid !== 1'b0) begin errors++; $display("FAIL ld_early_rvalid: got %0h exp 0", a_d_rvalid); end
        nxt(); #1;
        checks++; if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'd7) begin errors++; $display("FAIL ld_resp: got %0b/%0h exp 1/7", a_d_rvalid, a_d_rdata); end
        nxt();
    endtask

    task automatic test_lat3();
        nxt(); b_if_req = 1'b1; b_if_addr = 32'h0; #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL lat3_gnt: got %0h exp 1", b_if_gnt); end
        for (int k = 1; k <= 4; k++) begin
            nxt(); #1;
            checks++; if (b_if_gnt !== 1'b0) begin errors++; $display("FAIL lat3_busy_gnt: t+%0d got %0h exp 0", k, b_if_gnt); end
            checks++; if (b_if_rvalid !== (k == 4)) begin errors++; $display("FAIL lat3_rvalid: t+%0d got %0h exp %0h", k, b_if_rvalid, (k == 4)); end
        end
        checks++; if (b_if_rdata !== 32'hA5A50001) begin errors++; $display("FAIL lat3_rdata: got %0h exp a5a50001", b_if_rdata); end
        nxt(); #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL lat3_regrant: got %0h exp 1", b_if_gnt); end
        nxt(); b_if_req = 1'b0;
        for (int k = 0; k < 5; k++) nxt();
    endtask

    task automatic test_starve();
        int if_gnt_cycle;
        if_gnt_cycle = -1;
        nxt(); a_if_req = 1'b1; a_if_addr = 32'h0; a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'hDEAD;
`ifdef M_MEM_ARBITER_STARVE_GUARD_EN
        for (int k = 0; k <= 4; k++) begin
            #1;
            checks++; if ({a_d_gnt, a_if_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL starve_guard: t+%0d got %0b exp %0b", k, {a_d_gnt, a_if_gnt}, (k == 4) ? 2'b01 : 2'b10); end
            nxt();
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        nxt(); #1;
`else
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if ({a_d_gnt, a_if_gnt} !== 2'b10) begin errors++; $display("FAIL starve_strict: t+%0d got %0b exp 10", k, {a_d_gnt, a_if_gnt}); end
            nxt();
        end
        a_d_req = 1'b0; #1;
        checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL starve_release: got %0h exp 1", a_if_gnt); end
        nxt(); a_if_req = 1'b0;
        nxt(); #1;
`endif
        if (a_if_rvalid === 1'b1) if_gnt_cycle = 0;
        checks++; if (if_gnt_cycle != 0 || a_if_rdata !== 32'h00700093) begin errors++; $display("FAIL starve_resp: got %0b/%0h exp 1/00700093", a_if_rvalid, a_if_rdata); end
        nxt();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        idle_all();
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[0] = 32'h00700093;
        mem_a[1] = 32'h11111111;
        mem_a[2] = 32'h22222222;
        mem_b[0] = 32'hA5A50001;
        a_m_rdata = '0; b_m_rdata = '0; b_s1 = '0; b_s2 = '0;
        #2;
        test_reset();
        test_fetch_alone();
        test_reset_mid_read();
        test_simultaneous();
        test_store_load();
        test_lat3();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_mem_arbiter.md
Name: m_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single shared instruction/data memory of the multicycle processor.
- Instruction-fetch port (IF) and load/store port (D) compete for one memory port.
- Keeps one memory transaction in flight, counts out the memory read latency, and returns registered read data with a one-cycle valid pulse to the winning requester.
- Sits between the processor's fetch/LSU logic and the memory instance.

Parameters:
- ADDR_W, 32, byte address width on both requester ports and the memory port.
- DATA_W, 32, data word width.
- MEM_LAT, 1, memory read latency in cycles from command to w_m_rdata valid; legal range 1..7.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which IF is forced to win (used only with the optional feature).

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_if_req  in  1  fetch request; held until w_if_gnt.
- w_if_addr  in  ADDR_W  fetch address.
- w_if_gnt  out  1  fetch grant, one-cycle pulse.
- w_if_rvalid  out  1  fetch read data valid, one-cycle pulse.
- w_if_rdata  out  DATA_W  fetch read data.
- w_d_req  in  1  data request; held until w_d_gnt.
- w_d_we  in  1  1 = store, 0 = load.
- w_d_addr  in  ADDR_W  data address.
- w_d_wdata  in  DATA_W  store data.
- w_d_gnt  out  1  data grant, one-cycle pulse.
- w_d_rvalid  out  1  load data valid, one-cycle pulse.
- w_d_rdata  out  DATA_W  load data.
- w_m_en  out  1  memory command strobe.
- w_m_we  out  1  memory write enable.
- w_m_addr  out  ADDR_W  memory address.
- w_m_wdata  out  DATA_W  memory write data.
- w_m_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE immediately; latency counter and starvation counter clear; owner clears; the read-data register clears to 0.
  - All outputs are 0 while w_rst_n=0.
  - Reset during WAIT or RESP abandons the transaction: no rvalid is produced.
- IDLE state:
  - If either request is high, arbitrate in the same cycle (t).
  - D beats IF when both are high; with a single request, that request wins.
  - In cycle t the winner's gnt=1, and w_m_en/w_m_we/w_m_addr/w_m_wdata are driven combinationally from the winner's inputs.
  - For IF, w_m_we=0. For D, w_m_we=w_d_we.
  - When w_m_en=0, the w_m_* outputs are 0.
- Grant to a store: the memory writes at the end of cycle t; next state is IDLE, so the earliest next grant is t+1. No rvalid.
- Grant to a load or fetch:
  - Record the owner and go to WAIT with the counter set to MEM_LAT.
  - WAIT decrements the counter each cycle. In the cycle where the counter reaches 1 (cycle t+MEM_LAT), capture w_m_rdata into the read-data register and go to RESP.
- RESP state:
  - Lasts one cycle (t+MEM_LAT+1). The owner's rvalid=1 and the other rvalid=0.
  - w_if_rdata and w_d_rdata both show the read-data register, which holds its value until the next capture.
  - Next state is IDLE, so the earliest next grant is t+MEM_LAT+2.
- Requests during WAIT/RESP are ignored (no gnt). Requesters must hold req and address until gnt; the arbiter stores nothing for them.
- A requester may re-assert in the cycle after its gnt; that request is treated as a new one.
- A request dropped before its gnt is legal and is simply not granted.
- Memory contents are never modified except by a granted store.

Optional Feature:
- Macro: M_MEM_ARBITER_STARVE_GUARD_EN.
- Defined:
  - A counter increments at each IDLE arbitration where IF requests but D wins.
  - When the counter equals STARVE_MAX and both requests are high, IF wins; the counter clears whenever IF is granted.
  - The counter saturates at STARVE_MAX.
- Undefined: strict D-over-IF priority with no counter logic; IF can starve indefinitely.

Test Plan:
- Reset mid-read: grant an IF read, pull w_rst_n=0 in WAIT, release after 2 cycles -> all outputs 0 during reset, no rvalid afterwards, next IF request granted normally.
- Fetch alone, MEM_LAT=1: memory word 0 = 32'h00700093, IF req addr 0 at cycle t -> w_if_gnt at t, w_m_en=1 and w_m_addr=0 at t, w_if_rvalid=1 with w_if_rdata=32'h00700093 at t+2, w_d_rvalid stays 0.
- Simultaneous requests: IF read addr 4 and D load addr 8 both high at t -> w_d_gnt at t, w_if_gnt at t+3, w_d_rvalid at t+2, w_if_rvalid at t+5.
- Store then load: D store 32'd7 to addr 8 at t, then D load addr 8 -> load gnt at t+1, w_d_rvalid with w_d_rdata=32'd7 at t+3; no rvalid for the store.
- MEM_LAT=3, fetch: IF read at t -> rvalid at t+4; an IF request held through t+1..t+4 is granted no earlier than t+5.
- Starvation, STARVE_MAX=4: back-to-back D stores with IF req held from t:
  - With the macro defined: the first 4 arbitrations go to D and IF is granted at t+4.
  - With it undefined: IF is never granted while D req stays high.
